// File: rtl/tft_timing_controller.sv
// TFT LCD timing controller: raster generator, panel power sequencing and
// pixel stream alignment with sticky underflow / frame-sync error flags.
module tft_timing_controller #(
  parameter int unsigned C_H_ACTIVE      = 800,
  parameter int unsigned C_H_FP          = 40,
  parameter int unsigned C_H_SYNC        = 48,
  parameter int unsigned C_H_BP          = 40,
  parameter int unsigned C_V_ACTIVE      = 480,
  parameter int unsigned C_V_FP          = 13,
  parameter int unsigned C_V_SYNC        = 3,
  parameter int unsigned C_V_BP          = 29,
  parameter int unsigned C_POWER_DELAY   = 1024,
  parameter logic [23:0] C_UNDERFLOW_RGB = 24'h000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        pix_valid_i,
  input  logic        pix_sof_i,
  input  logic [23:0] pix_data_i,
  output logic        pix_ready_o,
  input  logic        flag_clr_i,
  output logic        tft_disp_o,
  output logic        tft_hsync_o,
  output logic        tft_vsync_o,
  output logic        tft_de_o,
  output logic [23:0] tft_rgb_o,
  output logic        frame_start_o,
  output logic        underflow_o,
  output logic        sync_err_o,
  output logic        busy_o
);

  localparam int unsigned CW       = 12;
  localparam int unsigned PW       = $clog2(C_POWER_DELAY + 1);
  localparam int unsigned H_TOTAL  = C_H_ACTIVE + C_H_FP + C_H_SYNC + C_H_BP;
  localparam int unsigned V_TOTAL  = C_V_ACTIVE + C_V_FP + C_V_SYNC + C_V_BP;
  localparam int unsigned HS_START = C_H_ACTIVE + C_H_FP;
  localparam int unsigned HS_END   = HS_START + C_H_SYNC;
  localparam int unsigned VS_START = C_V_ACTIVE + C_V_FP;
  localparam int unsigned VS_END   = VS_START + C_V_SYNC;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PWR_ON = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic [PW-1:0] pwr_cnt_q, pwr_cnt_d;
  logic          stop_q, stop_d;
  logic          disp_q, disp_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          de_q, de_d, fs_q, fs_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          uf_q, uf_d, se_q, se_d;
  logic          busy_q, busy_d;

  logic run_c, h_active_c, v_active_c, active_c, origin_c, last_c, xfer_c;
  logic uf_set_c, se_set_c;

  assign run_c      = (state_q == S_RUN);
  assign h_active_c = (h_q < CW'(C_H_ACTIVE));
  assign v_active_c = (v_q < CW'(C_V_ACTIVE));
  assign active_c   = h_active_c & v_active_c;
  assign origin_c   = (h_q == '0) & (v_q == '0);
  assign last_c     = (h_q == CW'(H_TOTAL - 1)) & (v_q == CW'(V_TOTAL - 1));

  // Vertical blanking drains stale pixels until an SOF sits at the stream head.
  always_comb begin
    pix_ready_o = 1'b0;
    if (run_c) begin
      if (active_c)         pix_ready_o = 1'b1;
      else if (!v_active_c) pix_ready_o = pix_valid_i & ~pix_sof_i;
    end
  end

  assign xfer_c = pix_valid_i & pix_ready_o;

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    v_d       = v_q;
    pwr_cnt_d = pwr_cnt_q;
    stop_d    = stop_q;
    disp_d    = disp_q;
    hsync_d   = 1'b1;
    vsync_d   = 1'b1;
    de_d      = 1'b0;
    fs_d      = 1'b0;
    rgb_d     = '0;
    uf_set_c  = 1'b0;
    se_set_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        h_d       = '0;
        v_d       = '0;
        pwr_cnt_d = '0;
        stop_d    = 1'b0;
        if (en_i) begin
          state_d = S_PWR_ON;
          disp_d  = 1'b1;
        end
      end
      S_PWR_ON: begin
        if (!en_i) begin
          state_d = S_IDLE;
          disp_d  = 1'b0;
        end else if (pwr_cnt_q == PW'(C_POWER_DELAY - 1)) begin
          state_d = S_RUN;
          h_d     = '0;
          v_d     = CW'(C_V_ACTIVE);
        end else begin
          pwr_cnt_d = pwr_cnt_q + PW'(1);
        end
      end
      S_RUN: begin
        de_d    = active_c;
        fs_d    = origin_c;
        hsync_d = ~((h_q >= CW'(HS_START)) & (h_q < CW'(HS_END)));
        vsync_d = ~((v_q >= CW'(VS_START)) & (v_q < CW'(VS_END)));
        if (active_c) begin
          rgb_d    = pix_valid_i ? pix_data_i : C_UNDERFLOW_RGB;
          uf_set_c = ~pix_valid_i;
          se_set_c = xfer_c & (origin_c ^ pix_sof_i);
        end
        stop_d = stop_q | ~en_i;
        if (h_q == CW'(H_TOTAL - 1)) begin
          h_d = '0;
          v_d = (v_q == CW'(V_TOTAL - 1)) ? '0 : v_q + CW'(1);
        end else begin
          h_d = h_q + CW'(1);
        end
        // Power-off only at the frame wrap so no partial frame reaches the panel.
        if (last_c && (stop_q || !en_i)) begin
          state_d = S_IDLE;
          disp_d  = 1'b0;
          stop_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        disp_d  = 1'b0;
      end
    endcase
    uf_d   = uf_set_c | (uf_q & ~flag_clr_i);
    se_d   = se_set_c | (se_q & ~flag_clr_i);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      h_q       <= '0;
      v_q       <= '0;
      pwr_cnt_q <= '0;
      stop_q    <= 1'b0;
      disp_q    <= 1'b0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      de_q      <= 1'b0;
      fs_q      <= 1'b0;
      rgb_q     <= '0;
      uf_q      <= 1'b0;
      se_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      v_q       <= v_d;
      pwr_cnt_q <= pwr_cnt_d;
      stop_q    <= stop_d;
      disp_q    <= disp_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      de_q      <= de_d;
      fs_q      <= fs_d;
      rgb_q     <= rgb_d;
      uf_q      <= uf_d;
      se_q      <= se_d;
      busy_q    <= busy_d;
    end
  end

  assign tft_disp_o    = disp_q;
  assign tft_hsync_o   = hsync_q;
  assign tft_vsync_o   = vsync_q;
  assign tft_de_o      = de_q;
  assign tft_rgb_o     = rgb_q;
  assign frame_start_o = fs_q;
  assign underflow_o   = uf_q;
  assign sync_err_o    = se_q;
  assign busy_o        = busy_q;

endmodule
